current_sense_adc: RTL and testbench
====================================

# current_sense_adc

Periodic SPI master for the motor-phase current-sense ADC (12-bit, AD7476-style: 4 leading zeros, then 12 data bits MSB-first). Drives the board's `CS` / `CS_CLK` / `CS_MISO` pins and produces the signed 13-bit `current` value consumed by the `coms` block. It also produces a per-sample overcurrent flag. It runs on the 32 MHz PLL clock alongside `pwm`, `quad` and `motorControl`.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles (4 gives 4 MHz SCLK). Legal range ≥1.
- `SAMPLE_PERIOD`, default 3200: conversion start interval in `clk` cycles (10 kHz). Must be ≥ 33*CLK_DIV+3.
- `OFFSET`, default 2048: zero-current ADC code, 0..4095.
- `LIMIT`, default 1800: overcurrent threshold on |current|, 0..4095.
- `clk` in 1: system clock (32 MHz). One clock domain.
- `reset` in 1: asynchronous, active-high.
- `cs_n` out 1: ADC chip select, active low.
- `sclk` out 1: ADC serial clock, idle high.
- `miso` in 1: ADC data. The top level synchronises it externally; this block uses it as-is.
- `raw` out 12: last ADC code.
- `current` out 13 signed: offset-corrected (optionally filtered) current.
- `current_valid` out 1: one-cycle pulse when `raw`/`current`/`overcurrent` update.
- `overcurrent` out 1: |unfiltered sample| > LIMIT, for the latest sample.

## Operation
- Period counter `pcnt` counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - At `pcnt==0` with the FSM in IDLE, a conversion starts.
  - A tick arriving while the FSM is not IDLE is ignored.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=1.
  - SETUP: `cs_n`=0, `sclk`=1, lasts CLK_DIV cycles.
  - SHIFT: 16 bits. Per bit, `sclk`=0 for CLK_DIV cycles, then `sclk`=1 for CLK_DIV cycles.
  - DONE: `cs_n`=1, `sclk`=1, lasts 1 cycle, then returns to IDLE.
- Sampling:
  - `miso` is sampled on the last `clk` cycle of each low half, i.e. the cycle before `sclk` rises.
  - Bits are shifted into a 16-bit register, MSB first.
- In DONE, `sr[11:0]` goes to `raw`. Bits `sr[15:12]` are discarded with no check.
- Arithmetic:
  - `sample = {1'b0,raw} - OFFSET`, 13-bit signed, range -4095..+4095, no saturation needed.
  - `overcurrent = (sample > LIMIT) || (sample < -LIMIT)`. This always uses the unfiltered sample.
  - `current = sample`, or the filter output (see Configuration).
- Reset, including reset asserted mid-conversion:
  - Immediately: `cs_n`=1, `sclk`=1.
  - Cleared to 0: FSM state IDLE, `pcnt`=0, shift register, `raw`, `current`, `current_valid`, `overcurrent`, filter history.
  - A partial frame is discarded and produces no valid pulse.
- The first conversion starts on the first `clk` edge after reset deasserts.

## Timing
- `cs_n` falls 1 cycle after the `pcnt==0` edge.
- `cs_n` stays low for exactly 33*CLK_DIV cycles: 132 at default.
- There are exactly 16 `sclk` rising edges per frame. The first rising edge is 2*CLK_DIV cycles after `cs_n` falls.
- `cs_n` rises on DONE entry. On the next cycle:
  - `raw`, `current` and `overcurrent` take their new values;
  - `current_valid`=1, for one cycle.
- Total latency from `cs_n` fall to `current_valid`: 33*CLK_DIV+1 cycles.
- Outputs hold their values between valid pulses.
- Conversions start every SAMPLE_PERIOD cycles, with no drift.

## Configuration
- `CURRENT_SENSE_FILTER_EN` defined:
  - `current` is a 4-tap boxcar average: sum of the last 4 `sample` values in a 15-bit signed accumulator, then arithmetic shift right by 2 (floor).
  - History resets to 0, so the first 3 outputs after reset include zeros.
  - Latency is unchanged.
- Not defined:
  - `current = sample` directly.
  - No history registers are built.

## Test plan
- Default params, ADC model returns code 0x0A00 (2560) -> `cs_n` low for 132 cycles, 16 `sclk` rises, `raw`=2560, `current`=+512, `overcurrent`=0, `current_valid` pulse 133 cycles after `cs_n` falls.
- ADC returns 0 -> `current`=-2048, `overcurrent`=1. ADC returns 3849 -> `current`=+1801, `overcurrent`=1. ADC returns 3848 -> `overcurrent`=0.
- Free run over 5 periods -> `cs_n` falling edges exactly 3200 cycles apart, one valid pulse per period.
- Reset asserted at the 8th `sclk` rise -> `cs_n`/`sclk` go high the same cycle, no valid pulse, all outputs 0. After release, a full frame starts on the next edge.
- Leading bits 0xF set with data 0x800 -> `raw`=2048, `current`=0 (upper nibble ignored).
- With `CURRENT_SENSE_FILTER_EN`, samples +400, +400, +400, +400, -400 -> `current` = 100, 200, 300, 400, 200.

Source files
------------

// File: rtl/current_sense_adc_if.sv
// Pin and result bundle for the current-sense ADC SPI master.
// The master modport is the ADC controller; the slave modport is the ADC plus result consumer.
interface current_sense_adc_if;
  logic                cs_n;
  logic                sclk;
  logic                miso;
  logic [11:0]         raw;
  logic signed [12:0]  current;
  logic                current_valid;
  logic                overcurrent;

  modport master (
    output cs_n,
    output sclk,
    input  miso,
    output raw,
    output current,
    output current_valid,
    output overcurrent
  );

  modport slave (
    input  cs_n,
    input  sclk,
    output miso,
    input  raw,
    input  current,
    input  current_valid,
    input  overcurrent
  );
endinterface

// File: rtl/current_sense_adc.sv
// Periodic SPI master for a 12-bit AD7476-style current-sense ADC with offset removal and an
// overcurrent flag. Define CURRENT_SENSE_FILTER_EN to add a 4-tap boxcar average on `current`.
module current_sense_adc #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 3200,
  parameter int unsigned OFFSET        = 2048,
  parameter int unsigned LIMIT         = 1800
) (
  input  logic                       clk,
  input  logic                       reset,
  current_sense_adc_if.master        bus
);

  localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PcntW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(CLK_DIV - 1);
  localparam logic [PcntW-1:0]  PcntLast  = PcntW'(SAMPLE_PERIOD - 1);
  localparam logic signed [12:0] OffsetS  = 13'(OFFSET);
  localparam logic signed [12:0] LimitS   = 13'(LIMIT);
  localparam logic signed [12:0] NegLimitS = -LimitS;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PcntW-1:0]   pcnt_q, pcnt_d;
  logic [3:0]         bit_q, bit_d;
  logic               phase_hi_q, phase_hi_d;
  logic [11:0]        sr_q, sr_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic [11:0]        raw_q, raw_d;
  logic signed [12:0] current_q, current_d;
  logic               valid_q, valid_d;
  logic               oc_q, oc_d;

  logic signed [12:0] sample;
  logic signed [12:0] cur_value;

  assign sample = $signed({1'b0, sr_q}) - OffsetS;

`ifdef CURRENT_SENSE_FILTER_EN
  logic signed [12:0] hist_q [3];
  logic signed [12:0] hist_d [3];
  logic signed [14:0] sum;

  function automatic logic signed [14:0] sx15(input logic signed [12:0] v);
    return $signed({{2{v[12]}}, v});
  endfunction

  always_comb begin
    sum       = sx15(sample) + sx15(hist_q[0]) + sx15(hist_q[1]) + sx15(hist_q[2]);
    cur_value = 13'(sum >>> 2);
    hist_d    = hist_q;
    if (state_q == StDone) begin
      hist_d[0] = sample;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '{default: '0};
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign cur_value = sample;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_hi_d = phase_hi_q;
    sr_d       = sr_q;
    raw_d      = raw_q;
    current_d  = current_q;
    oc_d       = oc_q;
    valid_d    = 1'b0;
    pcnt_d     = (pcnt_q == PcntLast) ? '0 : pcnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pcnt_q == '0) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == CntLast) begin
          state_d    = StShift;
          cnt_d      = '0;
          bit_d      = '0;
          phase_hi_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (!phase_hi_q) begin
            // Sample on the last low cycle; the four leading bits fall off the top.
            sr_d       = {sr_q[10:0], bus.miso};
            phase_hi_d = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_d = StDone;
          end else begin
            bit_d      = bit_q + 1'b1;
            phase_hi_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d   = StIdle;
        raw_d     = sr_q;
        current_d = cur_value;
        oc_d      = (sample > LimitS) || (sample < NegLimitS);
        valid_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Pins are registered from the next state so they change glitch-free with the FSM.
    cs_n_d = !((state_d == StSetup) || (state_d == StShift));
    sclk_d = !((state_d == StShift) && !phase_hi_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      bit_q      <= '0;
      phase_hi_q <= 1'b0;
      sr_q       <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      raw_q      <= '0;
      current_q  <= '0;
      valid_q    <= 1'b0;
      oc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      bit_q      <= bit_d;
      phase_hi_q <= phase_hi_d;
      sr_q       <= sr_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      raw_q      <= raw_d;
      current_q  <= current_d;
      valid_q    <= valid_d;
      oc_q       <= oc_d;
    end
  end

  assign bus.cs_n          = cs_n_q;
  assign bus.sclk          = sclk_q;
  assign bus.raw           = raw_q;
  assign bus.current       = current_q;
  assign bus.current_valid = valid_q;
  assign bus.overcurrent   = oc_q;

endmodule

// File: tb/tb_current_sense_adc.sv
// Self-checking bench for current_sense_adc: an ADC pin model plus a frame-level reference model.
module tb_current_sense_adc;
  localparam int ClkDiv = 4;
  localparam int Period = 3200;
  localparam int Offset = 2048;
  localparam int Limit  = 1800;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  current_sense_adc_if bus ();

  current_sense_adc #(
    .CLK_DIV      (ClkDiv),
    .SAMPLE_PERIOD(Period),
    .OFFSET       (Offset),
    .LIMIT        (Limit)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC pin model and frame monitor, evaluated mid-cycle
  logic [15:0] next_frame = '0;
  logic [15:0] cur_frame  = '0;
  logic        miso_r     = 1'b0;
  logic        prev_cs    = 1'b1;
  logic        prev_sclk  = 1'b1;
  int idx = -1, fall_cyc = 0, prev_fall_cyc = 0, fall_gap = 0;
  int low_cnt = 0, rises = 0, first_rise = 0, lat = 0, valid_count = 0;

  assign bus.miso = miso_r;

  always @(negedge clk) begin
    if (prev_cs && !bus.cs_n) begin
      prev_fall_cyc = fall_cyc;
      fall_cyc      = cyc;
      fall_gap      = cyc - prev_fall_cyc;
      cur_frame     = next_frame;
      idx           = 15;
      rises         = 0;
      low_cnt       = 0;
    end
    if (!bus.cs_n) low_cnt++;
    if (!prev_sclk && bus.sclk && !bus.cs_n) begin
      rises++;
      if (rises == 1) first_rise = cyc - fall_cyc;
      idx--;
    end
    miso_r = (!bus.cs_n && idx >= 0) ? cur_frame[idx[3:0]] : 1'b0;
    if (bus.current_valid) begin
      valid_count++;
      lat = cyc - fall_cyc;
    end
    prev_cs   = bus.cs_n;
    prev_sclk = bus.sclk;
  end

  // Reference model: history of unfiltered samples, newest first
  int hist[$];

  function automatic int model_current(input int s);
`ifdef CURRENT_SENSE_FILTER_EN
    int sum;
    hist.push_front(s);
    if (hist.size() > 4) void'(hist.pop_back());
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    return (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input logic [15:0] f, input bit timing, output bit ok);
    int vc;
    next_frame = f;
    vc = valid_count;
    ok = 1'b0;
    for (int i = 0; i < 2 * Period + 400; i++) begin
      tick();
      if (valid_count != vc) begin
        ok = 1'b1;
        break;
      end
    end
    check("valid_seen", int'(ok), 1);
    if (ok && timing) begin
      check("cs_low_cycles", low_cnt, 33 * ClkDiv);
      check("sclk_rises", rises, 16);
      check("first_rise", first_rise, 2 * ClkDiv);
      check("valid_latency", lat, 33 * ClkDiv + 1);
    end
  endtask

  task automatic check_outputs(input int raw, input int cur, input int oc);
    check("raw", int'(bus.raw), raw);
    check("current", int'(bus.current), cur);
    check("overcurrent", int'(bus.overcurrent), oc);
  endtask

  typedef struct {
    logic [15:0] frame;
    int          raw;
    int          sample;
    int          oc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok;
    int vc, raw, s, oc, ps, seen;
    logic [15:0] f;

    vecs[0] = '{16'h0A00, 2560,   512, 0};
    vecs[1] = '{16'h0000,    0, -2048, 1};
    vecs[2] = '{16'h0F09, 3849,  1801, 1};
    vecs[3] = '{16'h0F08, 3848,  1800, 0};
    vecs[4] = '{16'hF800, 2048,     0, 0};
    vecs[5] = '{16'h0FFF, 4095,  2047, 1};
    vecs[6] = '{16'h02F8,  760, -1288, 0};
    vecs[7] = '{16'h00F8,  248, -1800, 0};
    vecs[8] = '{16'h00F7,  247, -1801, 1};

    // Reset state
    repeat (3) tick();
    check("rst_cs_n", int'(bus.cs_n), 1);
    check("rst_sclk", int'(bus.sclk), 1);
    check("rst_valid", int'(bus.current_valid), 0);
    check_outputs(0, 0, 0);

`ifdef CURRENT_SENSE_FILTER_EN
    next_frame = 16'(2448);
    reset = 1'b0;
    tick();
    check("first_start", int'(bus.cs_n), 0);
    begin
      int exp_f[5] = '{100, 200, 300, 400, 200};
      int code_f[5] = '{2448, 2448, 2448, 2448, 1648};
      for (int i = 0; i < 5; i++) begin
        run_frame(16'(code_f[i]), 1'b0, ok);
        check("filter_current", int'(bus.current), exp_f[i]);
        void'(model_current(code_f[i] - Offset));
      end
    end
`else
    next_frame = vecs[0].frame;
    reset = 1'b0;
    tick();
    check("first_start", int'(bus.cs_n), 0);
`endif

    // Directed table, back-to-back periods
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].frame, 1'b1, ok);
      check_outputs(vecs[i].raw, model_current(vecs[i].sample), vecs[i].oc);
    end
    repeat (50) tick();
    check("raw_hold", int'(bus.raw), vecs[8].raw);

    // Free-running random frames against the model
    vc = valid_count;
    for (int p = 0; p < 6; p++) begin
      f   = 16'($urandom);
      raw = int'(f[11:0]);
      s   = raw - Offset;
      oc  = (s > Limit || s < -Limit) ? 1 : 0;
      run_frame(f, 1'b0, ok);
      check_outputs(raw, model_current(s), oc);
      check("period_gap", fall_gap, Period);
      check("valids_per_period", valid_count - vc, 1);
      vc = valid_count;
      tick();
      check("valid_width", int'(bus.current_valid), 0);
    end

    // Reset at the 8th sclk rise of a frame
    next_frame = 16'h0A00;
    seen = 0;
    for (int i = 0; i < 2 * Period && bus.cs_n; i++) tick();
    check("reset_frame_started", int'(bus.cs_n), 0);
    ps = int'(bus.sclk);
    for (int i = 0; i < 40 * ClkDiv && seen < 8; i++) begin
      tick();
      if (bus.sclk && ps == 0) seen++;
      ps = int'(bus.sclk);
    end
    check("reached_8th_rise", seen, 8);
    vc = valid_count;
    reset = 1'b1;
    #1;
    check("mid_rst_cs_n", int'(bus.cs_n), 1);
    check("mid_rst_sclk", int'(bus.sclk), 1);
    check("mid_rst_valid", int'(bus.current_valid), 0);
    check_outputs(0, 0, 0);
    hist.delete();
    repeat (3) tick();
    check("no_valid_in_reset", valid_count - vc, 0);
    next_frame = 16'h0C00;
    reset = 1'b0;
    tick();
    check("restart_cs_n", int'(bus.cs_n), 0);
    run_frame(16'h0C00, 1'b1, ok);
    check_outputs(3072, model_current(1024), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
